// File: rtl/xup_inv_vector_pipe_pkg.sv
// Shared package for the xup_inv_vector_pipe block.
// Holds the default data width and pipeline depth, and the function that
// sizes the occupancy counter so that it can represent 0..DEPTH.
// Optional feature macro (used in the top): XUP_INV_MASK_EN.
package xup_inv_pkg;

    localparam int SIZE_DEF  = 8;
    localparam int DEPTH_DEF = 3;

    // Bits needed to count from 0 up to and including depth.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/xup_inv_vector_pipe_if.sv
// Handshake/data bus of xup_inv_vector_pipe.
// Signals:
//   in_valid/in_ready/a         upstream valid-ready word
//   mask_load/mask_in           invert-mask update
//   out_valid/out_ready/y       downstream valid-ready word
//   occupancy                   number of occupied pipeline stages
// Modports: master = the side that feeds and drains the pipe,
//           slave  = the pipe itself.
interface xup_inv_vector_pipe_if
    import xup_inv_pkg::*;
#(
    parameter int SIZE  = SIZE_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int OCC_W = occ_w(DEPTH);

    logic             in_valid;
    logic             in_ready;
    logic [SIZE-1:0]  a;
    logic             mask_load;
    logic [SIZE-1:0]  mask_in;
    logic             out_valid;
    logic             out_ready;
    logic [SIZE-1:0]  y;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output in_valid, a, mask_load, mask_in, out_ready,
        input  in_ready, out_valid, y, occupancy
    );

    modport slave (
        input  in_valid, a, mask_load, mask_in, out_ready,
        output in_ready, out_valid, y, occupancy
    );

endinterface

// File: rtl/xup_inv_vector_pipe_stage.sv
// xup_inv_stage: one elastic pipeline register (data + valid).
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   in_vld_i       word offered by the previous stage (or upstream)
//   in_data_i      data of the offered word
//   nxt_rdy_i      next stage can take this stage's word this cycle
//   rdy_o          this stage can take a word this cycle
//   vld_o, data_o  registered valid and data of this stage
module xup_inv_stage #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_vld_i,
    input  logic [SIZE-1:0] in_data_i,
    input  logic            nxt_rdy_i,
    output logic            rdy_o,
    output logic            vld_o,
    output logic [SIZE-1:0] data_o
);
    logic            vld_q, vld_d;
    logic [SIZE-1:0] data_q, data_d;

    // Free slot, or the current word leaves in the same cycle.
    assign rdy_o = !vld_q || nxt_rdy_i;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (rdy_o) begin
            vld_d = in_vld_i;
            // Data only moves with a real word so the output holds when idle.
            if (in_vld_i) begin
                data_d = in_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/xup_inv_vector_pipe.sv
// xup_inv_vector_pipe: elastic DEPTH-stage pipeline whose captured words are
// a XOR mask. Ready propagates combinationally backwards through the stages,
// so a full pipe with out_ready=1 accepts and emits in the same cycle.
// Ports:
//   clk    sole clock
//   reset  synchronous active-high reset (clears stages, count, mask=all ones)
//   bus    xup_inv_vector_pipe_if.slave (handshakes, data, mask, occupancy)
// Macro XUP_INV_MASK_EN: when defined the mask is a register loaded by
// mask_load/mask_in; otherwise the mask is fixed all ones and mask_load/mask_in
// are ignored.
module xup_inv_vector_pipe
    import xup_inv_pkg::*;
#(
    parameter int SIZE  = SIZE_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    xup_inv_vector_pipe_if.slave bus
);
    localparam int OCC_W = occ_w(DEPTH);

    logic [SIZE-1:0]  mask;
    logic             stg_vld  [DEPTH];
    logic [SIZE-1:0]  stg_data [DEPTH];
    logic             stg_rdy  [DEPTH+1];
    logic             acc, emt;
    logic [OCC_W-1:0] count_q, count_d;

`ifdef XUP_INV_MASK_EN
    logic [SIZE-1:0] mask_q, mask_d;

    // A load on the accept edge only affects later words: stage 0 samples
    // a ^ mask_q before mask_q updates.
    always_comb begin
        mask_d = mask_q;
        if (bus.mask_load) begin
            mask_d = bus.mask_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '1;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign mask = mask_q;
`else
    logic unused_mask;

    assign mask        = '1;
    assign unused_mask = ^{bus.mask_load, bus.mask_in};
`endif

    assign stg_rdy[DEPTH] = bus.out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic            in_vld;
        logic [SIZE-1:0] in_data;

        if (k == 0) begin : g_head
            assign in_vld  = bus.in_valid;
            assign in_data = bus.a ^ mask;
        end else begin : g_body
            assign in_vld  = stg_vld[k-1];
            assign in_data = stg_data[k-1];
        end

        xup_inv_stage #(.SIZE(SIZE)) u_stage (
            .clk       (clk),
            .reset     (reset),
            .in_vld_i  (in_vld),
            .in_data_i (in_data),
            .nxt_rdy_i (stg_rdy[k+1]),
            .rdy_o     (stg_rdy[k]),
            .vld_o     (stg_vld[k]),
            .data_o    (stg_data[k])
        );
    end

    assign acc = bus.in_valid & stg_rdy[0];
    assign emt = stg_vld[DEPTH-1] & bus.out_ready;

    always_comb begin
        count_d = count_q;
        if (acc && !emt) begin
            count_d = count_q + OCC_W'(1);
        end else if (!acc && emt) begin
            count_d = count_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.in_ready  = stg_rdy[0];
    assign bus.out_valid = stg_vld[DEPTH-1];
    assign bus.y         = stg_data[DEPTH-1];
    assign bus.occupancy = count_q;

endmodule

// File: tb/tb_xup_inv_vector_pipe.sv
// Self-checking bench for xup_inv_vector_pipe. A queue of expected output
// words (a XOR mask at acceptance) is the reference; in_ready and occupancy
// are predicted from the queue length. Works with and without XUP_INV_MASK_EN.
module tb_xup_inv_vector_pipe;
    import xup_inv_pkg::*;

    localparam int SIZE  = 8;
    localparam int DEPTH = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    xup_inv_vector_pipe_if #(.SIZE(SIZE), .DEPTH(DEPTH)) bus ();

    xup_inv_vector_pipe #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int              n_chk  = 0;
    int              n_fail = 0;
    logic [SIZE-1:0] mq [$];
    logic [SIZE-1:0] mask_m;
    logic            stall_prev;
    logic [SIZE-1:0] stall_y;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, then update the model
    // with whatever transferred on the rising edge.
    task automatic step(output bit acc);
        bit              emt;
        logic [SIZE-1:0] a_s;
`ifdef XUP_INV_MASK_EN
        bit              ld;
        logic [SIZE-1:0] mi_s;
`endif
        @(negedge clk);
        if (stall_prev) begin
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_hold", 32'(bus.y), 32'(stall_y));
        end
        chk("in_ready", 32'(bus.in_ready), 32'((mq.size() < DEPTH) || bus.out_ready));
        chk("occupancy", 32'(bus.occupancy), 32'(mq.size()));
        if (mq.size() == 0) chk("valid_when_empty", 32'(bus.out_valid), 32'd0);
        acc = bus.in_valid && bus.in_ready;
        emt = bus.out_valid && bus.out_ready;
        a_s = bus.a;
`ifdef XUP_INV_MASK_EN
        ld   = bus.mask_load;
        mi_s = bus.mask_in;
`endif
        if (emt && mq.size() > 0) chk("y_order", 32'(bus.y), 32'(mq[0]));
        stall_prev = bus.out_valid && !bus.out_ready;
        stall_y    = bus.y;
        @(posedge clk);
        if (emt && mq.size() > 0) void'(mq.pop_front());
        if (acc) mq.push_back(a_s ^ mask_m);
`ifdef XUP_INV_MASK_EN
        if (ld) mask_m = mi_s;
`endif
        #1;
    endtask

    // Reset with a transfer and a mask load pending: reset must win over both.
    task automatic do_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 8'h11;
        bus.mask_load = 1'b1;
        bus.mask_in   = 8'h00;
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.mask_load = 1'b0;
        mq.delete();
        mask_m     = '1;
        stall_prev = 1'b0;
    endtask

    task automatic send(input logic [SIZE-1:0] v);
        bit acc = 1'b0;
        bus.a        = v;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(acc);
            if (acc) break;
        end
        chk("accepted", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        bus.in_valid  = 1'b0;
        bus.mask_load = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (mq.size() == 0 && !bus.out_valid) break;
            step(acc);
        end
        chk("drain_empty", 32'(mq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.mask_load = 1'b0;
        bus.mask_in   = '0;
        bus.out_ready = 1'b0;
        mask_m        = '1;
        stall_prev    = 1'b0;
        do_reset();

        // Back-to-back words, three-cycle latency, full throughput.
        bus.out_ready = 1'b1;
        send(8'h00);
        send(8'hA5);
        send(8'hFF);
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_y0", 32'(bus.y), 32'hFF);
        step(acc);
        chk("lat_y1", 32'(bus.y), 32'h5A);
        step(acc);
        chk("lat_y2", 32'(bus.y), 32'h00);
        drain();

`ifdef XUP_INV_MASK_EN
        // Mask load on the accept edge applies only to the following word.
        bus.mask_load = 1'b1;
        bus.mask_in   = 8'h0F;
        send(8'h00);
        bus.mask_load = 1'b0;
        send(8'h00);
        step(acc);
        chk("mask_old", 32'(bus.y), 32'hFF);
        step(acc);
        chk("mask_new", 32'(bus.y), 32'h0F);
        drain();
`else
        // Mask fixed all ones: a load request is ignored.
        bus.mask_load = 1'b1;
        bus.mask_in   = 8'h00;
        step(acc);
        bus.mask_load = 1'b0;
        send(8'h3C);
        step(acc);
        step(acc);
        chk("fixed_mask", 32'(bus.y), 32'hC3);
        drain();
`endif

        // Backpressure: fill, block the fourth word, then release.
        bus.out_ready = 1'b0;
        send(8'h01);
        send(8'h02);
        send(8'h03);
        bus.a        = 8'h04;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(acc);
            chk("full_block", 32'(acc), 32'd0);
        end
        chk("full_occupancy", 32'(bus.occupancy), 32'd3);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        step(acc);
        chk("full_accept_emit", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
        drain();

        // Reset mid-stream with two words in flight.
        bus.out_ready = 1'b0;
        send(8'h55);
        send(8'h66);
        step(acc);
        chk("pre_rst_occ", 32'(bus.occupancy), 32'd2);
        do_reset();
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        send(8'h3C);
        step(acc);
        step(acc);
        chk("post_rst_mask", 32'(bus.y), 32'hC3);
        drain();

        // Randomised traffic against the queue model.
        for (int i = 0; i < 1000; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.a         = SIZE'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
`ifdef XUP_INV_MASK_EN
            bus.mask_load = ($urandom_range(0, 15) == 0);
            bus.mask_in   = SIZE'($urandom);
`endif
            step(acc);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/xup_inv_vector_pipe.md
XUP_INV_VECTOR_PIPE -- requirements
Module: xup_inv_vector_pipe

Interface
REQ-001 SIZE, 8, data width in bits (>=1).
REQ-002 DEPTH, 3, number of pipeline register stages (>=1).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream word present on a.
REQ-006 in_ready  output  1  block accepts a word this cycle.
REQ-007 a  input  SIZE  input data word.
REQ-008 mask_load  input  1  load mask_in into mask register at next edge.
REQ-009 mask_in  input  SIZE  new invert mask; bit=1 inverts that bit.
REQ-010 out_valid  output  1  word present on y.
REQ-011 out_ready  input  1  downstream accepts word on y.
REQ-012 y  output  SIZE  output data word.
REQ-013 occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-014 Transfer occurs on an edge where valid and ready are both high; upstream side in_valid&in_ready, downstream side out_valid&out_ready.
REQ-015 Captured word SHALL be a XOR mask, using the mask value held before that edge.
REQ-016 Pipeline SHALL be elastic: stage k advances when stage k+1 is empty or stage k+1 advances in the same cycle; last stage advances on out_ready.
REQ-017 in_ready SHALL be high when stage 0 is empty or stage 0 advances this cycle (combinational ready chain, no bubble required).
REQ-018 With out_ready held high and no stalls, latency a->y SHALL be exactly DEPTH cycles, throughput one word per cycle.
REQ-019 y and out_valid SHALL be driven from the last stage register; y holds its value while out_valid=1 and out_ready=0.
REQ-020 Words SHALL leave in acceptance order; none dropped or duplicated under any out_ready pattern.
REQ-021 Full: occupancy=DEPTH and out_ready=0 -> in_ready=0; simultaneous accept and emit when full and out_ready=1.
REQ-022 occupancy SHALL increment on accept-only, decrement on emit-only, hold on both or neither.
REQ-023 mask_load and an accept on the same edge: accepted word uses old mask; new mask applies from the next accepted word.
REQ-024 Words already inside the pipeline SHALL NOT be altered by a mask change.

Reset
REQ-025 On reset edge: all stage valids cleared, out_valid=0, y=0, occupancy=0, mask=all ones.
REQ-026 Reset mid-stream SHALL discard all in-flight words; in_ready=1 in the first cycle after reset deasserts.
REQ-027 Reset SHALL take priority over mask_load and any transfer in the same cycle.

Configuration
REQ-028 Macro XUP_INV_MASK_EN defined: programmable mask register per REQ-008/015/023.
REQ-029 Macro XUP_INV_MASK_EN undefined: mask fixed all ones (every bit inverted); mask_load and mask_in present but ignored; no mask register synthesised.

Structure
REQ-030 Shared package xup_inv_pkg SHALL hold the default SIZE/DEPTH constants and the occupancy-width function.
REQ-031 One sub-module xup_inv_stage (one data+valid register with advance logic), instantiated DEPTH times in a generate loop.

Verification
REQ-032 SIZE=8, DEPTH=3, reset, out_ready=1, send a=8'h00,8'hA5,8'hFF back-to-back -> y=8'hFF,8'h5A,8'h00 on cycles 3,4,5 after first accept.
REQ-033 mask_load with mask_in=8'h0F on same edge as accept of a=8'h00, then a=8'h00 next -> y=8'hFF then 8'h0F.
REQ-034 out_ready=0, stream 4 words -> in_ready=0 after 3 accepts, occupancy=3, y stable; release out_ready -> 4 words out in order.
REQ-035 Random in_valid/out_ready for 1000 cycles vs scoreboard model -> no loss, reorder or duplication; occupancy matches model.
REQ-036 Assert reset with occupancy=2 -> next cycle out_valid=0, occupancy=0, y=8'h00, mask=8'hFF (a=8'h3C yields y=8'hC3).
REQ-037 Build without XUP_INV_MASK_EN, pulse mask_load with mask_in=8'h00, send a=8'h3C -> y=8'hC3.
